vram_shadow: RTL and testbench



---
 rtl/vram_shadow.sv | 190 +++++++++++++++++++
 tb/tb_vram_shadow.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_shadow.sv
// -----------------------------------------------------------------------------
// vram_shadow
//
// Dual-bank screen shadow RAM in front of the video controller. It snoops CPU
// writes to RAM 5 and RAM 7, queues them in a small FIFO and retires them in
// clk_sys cycles that the video fetch does not use. The video fetch owns the
// cycle after every ce_7mn, and its data appears on vram_dout two edges later.
//
// Optional feature macro: VRAM_SHADOW_CLEAR_EN
//   When defined, every reset starts a sweep that writes 0x00 to the whole
//   RAM. FIFO pops wait until the sweep ends, and busy is high during it.
//   When undefined, there is no sweep and busy is tied to 0.
//
// Ports
//   clk_sys    in   system clock (>= 4x the 7 MHz pixel enable)
//   nRESET     in   asynchronous active-low reset
//   ce_7mn     in   video fetch strobe, one clk_sys cycle wide
//   addr       in   CPU address bus
//   din        in   CPU write data
//   nMREQ      in   CPU memory request, active low
//   nWR        in   CPU write strobe, active low
//   m128       in   128K paging active
//   page_ram   in   RAM page mapped at 0xC000
//   vram_addr  in   video fetch address (held through the fetch slot)
//   vram_dout  out  registered fetch data
//   wr_ovf     out  sticky: a CPU write was dropped on a full FIFO
//   busy       out  clear sweep in progress
// -----------------------------------------------------------------------------
module vram_shadow #(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_AW     = 15
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              ce_7mn,
  input  logic [15:0]       addr,
  input  logic [7:0]        din,
  input  logic              nMREQ,
  input  logic              nWR,
  input  logic              m128,
  input  logic [2:0]        page_ram,
  input  logic [RAM_AW-1:0] vram_addr,
  output logic [7:0]        vram_dout,
  output logic              wr_ovf,
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = RAM_AW + 8;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  // ---------------------------------------------------------------------------
  // Write capture and bank decode
  // ---------------------------------------------------------------------------
  logic              wr_act, wr_act_d, capture;
  logic              map_hit, map_bank;
  logic [RAM_AW-1:0] map_addr;

  assign wr_act  = ~nMREQ & ~nWR;
  // Rising edge of the strobe: one capture per CPU write however long it is held.
  assign capture = wr_act & ~wr_act_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    map_hit  = 1'b0;
    map_bank = 1'b0;
    case (addr[15:14])
      2'b01: map_hit = 1'b1;
      2'b11: begin
        if (m128 && page_ram == 3'd5) begin
          map_hit = 1'b1;
        end else if (m128 && page_ram == 3'd7) begin
          map_hit  = 1'b1;
          map_bank = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign map_addr = {map_bank, addr[13:0]};

  // ---------------------------------------------------------------------------
  // Slot arbitration
  // ---------------------------------------------------------------------------
  logic video_slot;   // ce_7mn was high last cycle
  logic rd_valid;     // RAM read data from a video slot is valid this cycle
  logic clearing;
  logic [RAM_AW-1:0] clr_cnt;

  // ---------------------------------------------------------------------------
  // CPU write FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          push, push_ok, pop, empty, full;
  logic [DW-1:0] head;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push    = capture & map_hit;
  assign pop     = ~video_slot & ~empty & ~clearing;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign push_ok = push & (~full | pop);
  assign head    = fifo_mem[rd_ptr];

  // NOTE: FIFO storage and the RAM carry no reset; only pointers and flags do.
  always_ff @(posedge clk_sys) begin
    if (push_ok) fifo_mem[wr_ptr] <= {map_addr, din};
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      // NOTE: sequential state is always assigned with non-blocking <=.
      wr_act_d   <= 1'b0;
      video_slot <= 1'b0;
      rd_valid   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_ovf     <= 1'b0;
    end else begin
      wr_act_d   <= wr_act;
      video_slot <= ce_7mn;
      rd_valid   <= video_slot;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: ;
      endcase
      if (push && !push_ok) wr_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional clear sweep
  // ---------------------------------------------------------------------------
`ifdef VRAM_SHADOW_CLEAR_EN
  typedef enum logic {S_RUN, S_CLEAR} state_t;
  state_t state;

  assign clearing = (state == S_CLEAR);

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (state == S_CLEAR && !video_slot) begin
      clr_cnt <= clr_cnt + 1'b1;
      // Last address written this edge: run and drop busy from the next cycle.
      if (&clr_cnt) begin
        state <= S_RUN;
        busy  <= 1'b0;
      end
    end
  end
`else
  assign clearing = 1'b0;
  assign clr_cnt  = '0;
  assign busy     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Single-port shadow RAM
  // ---------------------------------------------------------------------------
  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        ram_q, ram_wd;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;

  assign ram_we = pop | (clearing & ~video_slot);
  assign ram_a  = video_slot ? vram_addr : (clearing ? clr_cnt : head[DW-1:8]);
  assign ram_wd = clearing ? 8'h00 : head[7:0];

  always_ff @(posedge clk_sys) begin
    if (ram_we)     ram[ram_a] <= ram_wd;
    if (video_slot) ram_q      <= ram[ram_a];
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET)       vram_dout <= 8'h00;
    else if (rd_valid) vram_dout <= ram_q;
  end

endmodule

// File: tb/tb_vram_shadow.sv
// -----------------------------------------------------------------------------
// tb_vram_shadow
//
// Directed bench for vram_shadow. Every stimulus step is written out in one
// initial block; expected values are hand-derived constants. Inputs change 1
// time unit after a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vram_shadow;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        ce_7mn;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ, nWR, m128;
  logic [2:0]  page_ram;
  logic [14:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        wr_ovf, busy;

  int tests  = 0;
  int errors = 0;
  logic [7:0] rd;

  vram_shadow #(.FIFO_DEPTH(4), .RAM_AW(15)) dut (
    .clk_sys   (clk_sys),
    .nRESET    (nRESET),
    .ce_7mn    (ce_7mn),
    .addr      (addr),
    .din       (din),
    .nMREQ     (nMREQ),
    .nWR       (nWR),
    .m128      (m128),
    .page_ram  (page_ram),
    .vram_addr (vram_addr),
    .vram_dout (vram_dout),
    .wr_ovf    (wr_ovf),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // One CPU write: strobe low for one cycle, then high for one cycle.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    tick(1);
    nMREQ = 1'b1; nWR = 1'b1;
    tick(1);
  endtask

  // Video fetch: ce_7mn in cycle N, vram_dout sampled in N+3, plus one spare
  // cycle so the next ce_7mn is at least four cycles later.
  task automatic fetch(input logic [14:0] va, output logic [7:0] d);
    vram_addr = va; ce_7mn = 1'b1;
    tick(1);
    ce_7mn = 1'b0;
    tick(2);
    d = vram_dout;
    tick(1);
  endtask

  task automatic pulse_reset();
    nRESET = 1'b0;
    #3;
    nRESET = 1'b1;
    tick(1);
  endtask

`ifdef VRAM_SHADOW_CLEAR_EN
  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 40000) begin
      tick(1);
      n++;
    end
    check1(tag, busy, 1'b0);
  endtask
`endif

  initial begin
    nRESET = 1'b0; ce_7mn = 1'b0; addr = '0; din = '0;
    nMREQ = 1'b1; nWR = 1'b1; m128 = 1'b0; page_ram = 3'd0; vram_addr = '0;
    #12;
    check8("reset_dout", vram_dout, 8'h00);
    check1("reset_ovf", wr_ovf, 1'b0);
`ifdef VRAM_SHADOW_CLEAR_EN
    check1("reset_busy", busy, 1'b1);
`else
    check1("reset_busy", busy, 1'b0);
`endif
    nRESET = 1'b1;
    tick(2);

`ifdef VRAM_SHADOW_CLEAR_EN
    // Mid-sweep reset restarts the sweep; a write captured during the new
    // sweep is held in the FIFO and lands after busy falls.
    tick(100);
    pulse_reset();
    check1("busy_reasserts", busy, 1'b1);
    cpu_write(16'h4005, 8'h6B);
    wait_not_busy("sweep_done");
    tick(3);
    fetch(15'h0005, rd); check8("sweep_write_kept", rd, 8'h6B);
    fetch(15'h0000, rd); check8("sweep_zero_lo", rd, 8'h00);
    fetch(15'h7FFF, rd); check8("sweep_zero_hi", rd, 8'h00);
`endif

    // Basic bank 5 write and fetch, including exact N+3 latency.
    cpu_write(16'h4000, 8'hA5);
    vram_addr = 15'h0000; ce_7mn = 1'b1;
    tick(1);
    ce_7mn = 1'b0;
    tick(1);
    check8("latency_n2_old", vram_dout, 8'h00);
    tick(1);
    check8("latency_n3_new", vram_dout, 8'hA5);
    tick(1);
    check1("basic_ovf", wr_ovf, 1'b0);

    // 128K paging: page 7 maps 0xC123 to bank 7.
    m128 = 1'b1; page_ram = 3'd7;
    cpu_write(16'hC123, 8'h3C);
    fetch(15'h4123, rd); check8("page7_write", rd, 8'h3C);
    page_ram = 3'd3;
    cpu_write(16'hC123, 8'h77);
    fetch(15'h4123, rd); check8("page3_ignored", rd, 8'h3C);
    m128 = 1'b0; page_ram = 3'd7;
    cpu_write(16'hC123, 8'h99);
    fetch(15'h4123, rd); check8("m128_off_ignored", rd, 8'h3C);
    m128 = 1'b1; page_ram = 3'd5;
    cpu_write(16'hC200, 8'h5A);
    fetch(15'h0200, rd); check8("page5_write", rd, 8'h5A);
    m128 = 1'b0;
    cpu_write(16'h0000, 8'h11);
    cpu_write(16'h8000, 8'h22);
    fetch(15'h0000, rd); check8("rom_bank2_ignored", rd, 8'hA5);

    // Held strobe: data changes while low, only the first value is captured.
    addr = 16'h4010; din = 8'h11; nMREQ = 1'b0; nWR = 1'b0;
    tick(1);
    din = 8'h22;
    tick(19);
    nMREQ = 1'b1; nWR = 1'b1;
    tick(2);
    fetch(15'h0010, rd); check8("held_strobe_one_push", rd, 8'h11);

    // Capture in a video slot for the same address: old data, then new.
    cpu_write(16'h4050, 8'h77);
    vram_addr = 15'h0050; ce_7mn = 1'b1;
    tick(1);
    ce_7mn = 1'b0;
    addr = 16'h4050; din = 8'h88; nMREQ = 1'b0; nWR = 1'b0;
    tick(1);
    nMREQ = 1'b1; nWR = 1'b1;
    tick(1);
    check8("slot_collide_old", vram_dout, 8'h77);
    tick(1);
    fetch(15'h0050, rd); check8("slot_collide_new", rd, 8'h88);

    // Overflow: ce_7mn held high so every cycle is a video slot and nothing
    // pops. Entries 1-4 fit, the 5th is dropped.
    cpu_write(16'h4064, 8'hEE);
    ce_7mn = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) cpu_write(16'h4060 + 16'(i), 8'(i + 1));
    ce_7mn = 1'b0;
    tick(8);
    check1("ovf_set", wr_ovf, 1'b1);
    fetch(15'h0060, rd); check8("ovf_entry1", rd, 8'h01);
    fetch(15'h0061, rd); check8("ovf_entry2", rd, 8'h02);
    fetch(15'h0062, rd); check8("ovf_entry3", rd, 8'h03);
    fetch(15'h0063, rd); check8("ovf_entry4", rd, 8'h04);
    fetch(15'h0064, rd); check8("ovf_entry5_dropped", rd, 8'hEE);
    tick(10);
    check1("ovf_sticky", wr_ovf, 1'b1);

    // Reset clears flags and output but not RAM contents.
    pulse_reset();
    check1("post_reset_ovf", wr_ovf, 1'b0);
    check8("post_reset_dout", vram_dout, 8'h00);
`ifdef VRAM_SHADOW_CLEAR_EN
    wait_not_busy("sweep2_done");
    tick(2);
    fetch(15'h0060, rd); check8("post_reset_ram_cleared", rd, 8'h00);
`else
    fetch(15'h0060, rd); check8("post_reset_ram_kept", rd, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
